// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter: CPU load/store path vs. external (DMA/debug) requester.
// Optional stall statistics counter built only when MEM_ARB_STATS_EN is defined.
`timescale 1ns/1ps

// state   | meaning
// OWN_CPU | CPU owns the memory port (park state after reset)
// OWN_EXT | external requester owns the memory port, CPU stalls if requesting
module mem_arbiter #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  owner_t          r_owner;
  owner_t          w_owner_nxt;
  logic [BW-1:0]   r_burst;
  logic [BW-1:0]   w_burst_nxt;
  logic            w_ext_own;
  logic            w_own_req;
  logic            w_own_we;
  logic            w_other_req;
  logic            w_at_limit;

  assign w_ext_own   = (r_owner == OWN_EXT);
  assign w_own_req   = w_ext_own ? ext_req : cpu_req;
  assign w_own_we    = w_ext_own ? ext_we  : cpu_we;
  assign w_other_req = w_ext_own ? cpu_req : ext_req;
  assign w_at_limit  = (r_burst == BURST_LAST);

  assign mem_addr  = w_ext_own ? ext_addr  : cpu_addr;
  assign mem_wdata = w_ext_own ? ext_wdata : cpu_wdata;
  // Write strobe is gated by reset so an abandoned access can never land in memory.
  assign mem_write = rst & w_own_req & w_own_we;
  assign mem_read  = w_own_req & ~w_own_we;

  assign cpu_rdata = mem_rdata;
  assign ext_rdata = mem_rdata;
  assign cpu_stall = cpu_req & w_ext_own;
  assign ext_ack   = ext_req & w_ext_own;

  always_comb begin
    w_owner_nxt = r_owner;
    w_burst_nxt = r_burst;
    if (r_owner == OWN_CPU) begin
      if (ext_req && (!cpu_req || w_at_limit)) w_owner_nxt = OWN_EXT;
    end else begin
      if (!ext_req || (cpu_req && w_at_limit)) w_owner_nxt = OWN_CPU;
    end
    if (w_owner_nxt != r_owner) begin
      w_burst_nxt = '0;
    end else if (!w_other_req) begin
      w_burst_nxt = '0;
    end else if (w_own_req) begin
      w_burst_nxt = r_burst + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_CPU;
      r_burst <= '0;
    end else begin
      r_owner <= w_owner_nxt;
      r_burst <= w_burst_nxt;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (cpu_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
